// File: rtl/prog_clk_divider_pkg.sv
// Shared constants and helpers for the programmable multi-channel clock divider.
package prog_clk_divider_pkg;

   localparam int unsigned CNT_W_DEF       = 24;
   localparam int unsigned DEFAULT_DIV_DEF = 2499999;

   typedef enum logic {
      MODE_TOGGLE = 1'b0,
      MODE_PULSE  = 1'b1
   } mode_e;

   // Channel-index width; a single channel still needs one select bit.
   function automatic int unsigned ch_idx_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/prog_clk_divider_if.sv
// Configuration write channel: valid/ready handshake carrying channel index, divide value and mode.
interface prog_clk_divider_if
   import prog_clk_divider_pkg::*;
#(
   parameter int unsigned NUM_CH = 4,
   parameter int unsigned CNT_W  = CNT_W_DEF
);
   localparam int unsigned CH_W = ch_idx_w(NUM_CH);

   logic             cfg_valid;
   logic             cfg_ready;
   logic [CH_W-1:0]  cfg_ch;
   logic [CNT_W-1:0] cfg_div;
   logic             cfg_mode;

   modport master (output cfg_valid, output cfg_ch, output cfg_div, output cfg_mode, input cfg_ready);
   modport slave  (input cfg_valid, input cfg_ch, input cfg_div, input cfg_mode, output cfg_ready);

endinterface

// File: rtl/clk_div_channel.sv
// One divider channel: free-running counter, terminal-count tick, toggle/pulse output,
// and a shadow config that only takes effect at a period boundary.
module clk_div_channel
   import prog_clk_divider_pkg::*;
#(
   parameter int unsigned      CNT_W       = CNT_W_DEF,
   parameter logic [CNT_W-1:0] DEFAULT_DIV = CNT_W'(DEFAULT_DIV_DEF)
) (
   input  logic             clk_input,
   input  logic             reset,
   input  logic             en,
   input  logic             sync_restart,
   input  logic             wr,
   input  logic [CNT_W-1:0] wr_div,
   input  logic             wr_mode,
   output logic             pend,
   output logic             clk_out,
   output logic             tick
);

   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] div_a;
   logic [CNT_W-1:0] div_s;
   logic             mode_a;
   logic             mode_s;
   logic             tc_c;
   logic             apply_c;

   // Shadow config moves to active only where a period begins afresh.
   always_comb begin
      tc_c    = en && (cnt == div_a);
      apply_c = pend && (sync_restart || !en || tc_c);
   end

   always_ff @(posedge clk_input) begin
      if (reset) begin
         cnt     <= '0;
         clk_out <= 1'b0;
         tick    <= 1'b0;
         pend    <= 1'b0;
         div_a   <= DEFAULT_DIV;
         div_s   <= DEFAULT_DIV;
         mode_a  <= 1'(MODE_TOGGLE);
         mode_s  <= 1'(MODE_TOGGLE);
      end else begin
         if (sync_restart || !en) begin
            cnt     <= '0;
            clk_out <= 1'b0;
            tick    <= 1'b0;
         end else if (tc_c) begin
            cnt  <= '0;
            tick <= 1'b1;
            // A mode switch restarts the output waveform from low.
            if (apply_c && (mode_s != mode_a))
               clk_out <= 1'b0;
            else if (mode_a == 1'(MODE_PULSE))
               clk_out <= 1'b1;
            else
               clk_out <= ~clk_out;
         end else begin
            cnt  <= cnt + CNT_W'(1);
            tick <= 1'b0;
            if (mode_a == 1'(MODE_PULSE))
               clk_out <= 1'b0;
         end

         // wr is only possible while pend is clear, so it never collides with apply.
         if (apply_c) begin
            div_a  <= div_s;
            mode_a <= mode_s;
            pend   <= 1'b0;
         end else if (wr) begin
            div_s  <= wr_div;
            mode_s <= wr_mode;
            pend   <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/prog_clk_divider.sv
// Multi-channel programmable clock divider: channel array plus config decode and ready mux.
module prog_clk_divider
   import prog_clk_divider_pkg::*;
#(
   parameter int unsigned NUM_CH      = 4,
   parameter int unsigned CNT_W       = CNT_W_DEF,
   parameter int unsigned DEFAULT_DIV = DEFAULT_DIV_DEF
) (
   input  logic              clk_input,
   input  logic              reset,
   input  logic [NUM_CH-1:0] ch_en,
   input  logic              sync_restart,
   prog_clk_divider_if.slave cfg,
   output logic [NUM_CH-1:0] clk_out,
   output logic [NUM_CH-1:0] tick
);

   localparam int unsigned CH_W  = ch_idx_w(NUM_CH);
   localparam int unsigned PAD_W = 1 << CH_W;

   logic [NUM_CH-1:0] pend;
   logic [NUM_CH-1:0] wr;
   logic [PAD_W-1:0]  pend_pad;
   logic              in_range;

   // Out-of-range indices are always ready and their writes go nowhere.
   always_comb begin
      pend_pad      = PAD_W'(pend);
      in_range      = (32'(cfg.cfg_ch) < NUM_CH);
      cfg.cfg_ready = in_range ? ~pend_pad[cfg.cfg_ch] : 1'b1;
      for (int i = 0; i < NUM_CH; i++)
         wr[i] = cfg.cfg_valid && cfg.cfg_ready && !reset && (cfg.cfg_ch == CH_W'(i));
   end

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      clk_div_channel #(
         .CNT_W       (CNT_W),
         .DEFAULT_DIV (CNT_W'(DEFAULT_DIV))
      ) u_ch (
         .clk_input    (clk_input),
         .reset        (reset),
         .en           (ch_en[g]),
         .sync_restart (sync_restart),
         .wr           (wr[g]),
         .wr_div       (cfg.cfg_div),
         .wr_mode      (cfg.cfg_mode),
         .pend         (pend[g]),
         .clk_out      (clk_out[g]),
         .tick         (tick[g])
      );
   end

endmodule
